// File: rtl/store_buffer.sv
// Post-commit store buffer: an in-order FIFO of lane-aligned stores that drains
// toward the data-memory port, with byte-granular store-to-load forwarding.
//
// Handshakes:
//   push  : an entry is written on a rising edge where pushValid && pushReady.
//           pushReady depends only on occupancy, never on storeComplete.
//   drain : storeValid presents the head entry. A storeComplete pulse while
//           storeValid is high retires it on that edge. storeComplete is
//           ignored while storeValid is low.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pushValid,
  output logic                  pushReady,
  input  logic [ADDR_WIDTH-1:0] pushAddress,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic [BYTES-1:0]      pushByteEnable,
  output logic                  storeValid,
  output logic [ADDR_WIDTH-1:0] storeAddress,
  output logic [DATA_WIDTH-1:0] storeData,
  output logic [BYTES-1:0]      storeByteEnable,
  input  logic                  storeComplete,
  input  logic                  loadValid,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  input  logic [BYTES-1:0]      loadByteEnable,
  output logic [DATA_WIDTH-1:0] forwardData,
  output logic [BYTES-1:0]      forwardMask,
  output logic                  loadHit,
  output logic                  loadConflict,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(BYTES);

  // Entry storage; valid bits mark occupied slots between head and tail.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [BYTES-1:0]      be_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   head_q;
  logic [PTR_W:0]   tail_q;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;

  logic full;
  logic push_fire;
  logic retire_fire;

  assign head_idx    = head_q[PTR_W-1:0];
  assign tail_idx    = tail_q[PTR_W-1:0];
  assign count       = CNT_W'(tail_q - head_q);
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign pushReady   = !full;
  assign push_fire   = pushValid && pushReady;
  assign storeValid  = !empty;
  assign retire_fire = storeComplete && storeValid;

  // Head entry goes straight out of the registers; zeroed while nothing is held.
  assign storeAddress    = storeValid ? addr_q[head_idx] : '0;
  assign storeData       = storeValid ? data_q[head_idx] : '0;
  assign storeByteEnable = storeValid ? be_q[head_idx]   : '0;

  // Pointer, valid-bit and entry updates for push and retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      // A push never targets the head slot while it is retiring: a push
      // needs a free slot, and a retire needs the head to be occupied.
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (push_fire) begin
        addr_q[tail_idx]  <= pushAddress;
        data_q[tail_idx]  <= pushData;
        be_q[tail_idx]    <= pushByteEnable;
        valid_q[tail_idx] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match per lane wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             word_match;
    forwardData = '0;
    forwardMask = '0;
    idx         = '0;
    word_match  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx        = head_idx + PTR_W'(k);
      word_match = (((addr_q[idx] ^ loadAddress) >> OFF_W) == '0);
      for (int b = 0; b < BYTES; b++) begin
        if (loadValid && valid_q[idx] && word_match &&
            be_q[idx][b] && loadByteEnable[b]) begin
          forwardMask[b]        = 1'b1;
          forwardData[b*8 +: 8] = data_q[idx][b*8 +: 8];
        end
      end
    end
  end

  // Hit when every requested byte is covered; conflict when only some are.
  assign loadHit      = loadValid && (loadByteEnable != '0) &&
                        ((loadByteEnable & ~forwardMask) == '0);
  assign loadConflict = (forwardMask != '0) && !loadHit;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
// A queue of expected entries is filled when the bench's own occupancy model
// says a push is accepted and popped when a completion retires the head.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BY    = DW / 8;
  localparam int EW    = AW + DW + BY;

  logic          clock;
  logic          reset;
  logic          pushValid;
  logic          pushReady;
  logic [AW-1:0] pushAddress;
  logic [DW-1:0] pushData;
  logic [BY-1:0] pushByteEnable;
  logic          storeValid;
  logic [AW-1:0] storeAddress;
  logic [DW-1:0] storeData;
  logic [BY-1:0] storeByteEnable;
  logic          storeComplete;
  logic          loadValid;
  logic [AW-1:0] loadAddress;
  logic [BY-1:0] loadByteEnable;
  logic [DW-1:0] forwardData;
  logic [BY-1:0] forwardMask;
  logic          loadHit;
  logic          loadConflict;
  logic [2:0]    count;
  logic          empty;

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .pushValid(pushValid), .pushReady(pushReady), .pushAddress(pushAddress),
    .pushData(pushData), .pushByteEnable(pushByteEnable),
    .storeValid(storeValid), .storeAddress(storeAddress), .storeData(storeData),
    .storeByteEnable(storeByteEnable), .storeComplete(storeComplete),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadByteEnable(loadByteEnable),
    .forwardData(forwardData), .forwardMask(forwardMask), .loadHit(loadHit),
    .loadConflict(loadConflict), .count(count), .empty(empty)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle of push/complete; called just after a rising edge.
  task automatic do_cycle(input bit pv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BY-1:0] be, input bit comp);
    int            sz;
    logic [EW-1:0] head_e;
    pushValid      = pv;
    pushAddress    = a;
    pushData       = d;
    pushByteEnable = be;
    storeComplete  = comp;
    sz = exp_q.size();
    #4;
    check_eq("pushReady", pushReady, 64'(sz < DEPTH));
    check_eq("storeValid", storeValid, 64'(sz > 0));
    if (comp && sz > 0) begin
      head_e = exp_q[0];
      check_eq("storeAddress", storeAddress, head_e[EW-1 -: AW]);
      check_eq("storeData", storeData, head_e[DW+BY-1 -: DW]);
      check_eq("storeByteEnable", storeByteEnable, head_e[BY-1:0]);
    end
    @(posedge clock);
    if (comp && sz > 0) void'(exp_q.pop_front());
    if (pv && sz < DEPTH) exp_q.push_back({a, d, be});
    #1;
    pushValid     = 1'b0;
    storeComplete = 1'b0;
    check_eq("count", count, exp_q.size());
    check_eq("empty", empty, 64'(exp_q.size() == 0));
  endtask

  // Combinational lookup; called between cycles.
  task automatic do_load(input string tag, input logic [AW-1:0] a, input logic [BY-1:0] be,
                         input logic [DW-1:0] xd, input logic [BY-1:0] xm,
                         input bit xh, input bit xc);
    loadValid      = 1'b1;
    loadAddress    = a;
    loadByteEnable = be;
    #1;
    check_eq({tag, ".forwardData"}, forwardData, xd);
    check_eq({tag, ".forwardMask"}, forwardMask, xm);
    check_eq({tag, ".loadHit"}, loadHit, xh);
    check_eq({tag, ".loadConflict"}, loadConflict, xc);
    loadValid = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH; i++)
      if (exp_q.size() > 0) do_cycle(1'b0, '0, '0, '0, 1'b1);
    check_eq("drained", exp_q.size(), 0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    pushValid      = 1'b0;
    pushAddress    = '0;
    pushData       = '0;
    pushByteEnable = '0;
    storeComplete  = 1'b0;
    loadValid      = 1'b0;
    loadAddress    = '0;
    loadByteEnable = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    check_eq("rst.count", count, 0);
    check_eq("rst.empty", empty, 1);
    check_eq("rst.storeValid", storeValid, 0);
    check_eq("rst.pushReady", pushReady, 1);
    check_eq("rst.storeAddress", storeAddress, 0);
    check_eq("rst.forwardMask", forwardMask, 0);
    do_cycle(1'b0, '0, '0, '0, 1'b1);

    // Fill, then a dropped fifth push, then in-order drain
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 32'h10 + 32'(4 * i), $urandom, 4'hF, 1'b0);
    check_eq("fill.pushReady", pushReady, 0);
    do_cycle(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0);
    drain_all();

    // Youngest entry wins per lane
    do_cycle(1'b1, 32'h100, 32'hAABBCCDD, 4'b1111, 1'b0);
    do_cycle(1'b1, 32'h100, 32'h000000EE, 4'b0001, 1'b0);
    do_load("young", 32'h100, 4'b1111, 32'hAABBCCEE, 4'b1111, 1'b1, 1'b0);
    do_load("young_hi", 32'h102, 4'b1100, 32'hAABB0000, 4'b1100, 1'b1, 1'b0);
    drain_all();

    // Partial overlap, unrelated word, and after drain
    do_cycle(1'b1, 32'h200, 32'h0000BEEF, 4'b0011, 1'b0);
    do_load("partial", 32'h200, 4'b1111, 32'h0000BEEF, 4'b0011, 1'b0, 1'b1);
    do_load("other", 32'h204, 4'b1111, 32'h0, 4'b0000, 1'b0, 1'b0);
    do_load("empty_be", 32'h200, 4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);
    loadAddress    = 32'h200;
    loadByteEnable = 4'b1111;
    #1 check_eq("idle.forwardMask", forwardMask, 0);
    check_eq("idle.loadConflict", loadConflict, 0);
    drain_all();
    do_load("drained", 32'h200, 4'b1111, 32'h0, 4'b0000, 1'b0, 1'b0);

    // A push is not visible to a lookup in its own cycle
    pushValid = 1'b1; pushAddress = 32'h300; pushData = 32'h11223344; pushByteEnable = 4'hF;
    do_load("same_cycle", 32'h300, 4'b1111, 32'h0, 4'b0000, 1'b0, 1'b0);
    do_cycle(1'b1, 32'h300, 32'h11223344, 4'hF, 1'b0);
    do_load("next_cycle", 32'h300, 4'b1111, 32'h11223344, 4'b1111, 1'b1, 1'b0);

    // Simultaneous push+complete at count 2 and at full
    do_cycle(1'b1, 32'h304, $urandom, 4'hF, 1'b0);
    do_cycle(1'b1, 32'h308, $urandom, 4'hF, 1'b1);
    check_eq("simul2.count", count, 2);
    do_cycle(1'b1, 32'h30C, $urandom, 4'hF, 1'b0);
    do_cycle(1'b1, 32'h310, $urandom, 4'hF, 1'b0);
    do_cycle(1'b1, 32'h314, $urandom, 4'hF, 1'b1);
    check_eq("simul4.count", count, 3);
    drain_all();

    // Back-to-back push/complete pairs across pointer wrap
    for (int i = 0; i < 10; i++)
      do_cycle(1'b1, 32'h400 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 1'b1);
    drain_all();

    // Random mix against the scoreboard
    for (int i = 0; i < 40; i++)
      do_cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain_all();

    // Asynchronous reset mid-handshake drops the entry
    do_cycle(1'b1, 32'h500, 32'hCAFEF00D, 4'hF, 1'b0);
    storeComplete = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_eq("arst.storeValid", storeValid, 0);
    check_eq("arst.count", count, 0);
    check_eq("arst.empty", empty, 1);
    check_eq("arst.pushReady", pushReady, 1);
    check_eq("arst.storeAddress", storeAddress, 0);
    exp_q.delete();
    storeComplete = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    do_cycle(1'b1, 32'h600, 32'h0BADF00D, 4'hF, 1'b0);
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
